// File: rtl/addsub_pkg.sv
// Shared encodings and defaults for the sequential add/subtract unit.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 16;

  // Counter width for n passes; a single-pass configuration still needs one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational W-bit slice adder; c_msb is the carry into the slice's top bit.
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int W = DEF_SLICE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] w_full;

  // Full-width sum with one extra bit for the carry.
  always_comb begin
    w_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

  assign s     = w_full[W-1:0];
  assign cout  = w_full[W];
  // Carry into the MSB is recovered from the MSB's sum equation.
  assign c_msb = a[W-1] ^ b[W-1] ^ w_full[W-1];

endmodule

// File: rtl/seq_addsub_ctrl.sv
// Multi-cycle add/subtract controller, LSB-first over one shared slice adder.
// Optional signed overflow output enabled by defining ADDSUB_OVERFLOW_EN.
module seq_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
`ifdef ADDSUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = cnt_bits(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_carry_out;
  logic [CW-1:0]    r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [SLICE-1:0] w_a_k;
  logic [SLICE-1:0] w_b_k;
  logic [SLICE-1:0] w_s_k;
  logic             w_cout;
  logic             w_last;
`ifdef ADDSUB_OVERFLOW_EN
  logic             w_c_msb;
  logic             r_overflow;
`else
  logic             w_unused_c_msb;
`endif

  assign w_a_k  = r_a[r_cnt*SLICE +: SLICE];
  assign w_b_k  = r_b[r_cnt*SLICE +: SLICE];
  assign w_last = (r_cnt == LAST);

  addsub_slice #(.W(SLICE)) u_slice (
    .a     (w_a_k),
    .b     (w_b_k),
    .cin   (r_carry),
    .s     (w_s_k),
    .cout  (w_cout),
`ifdef ADDSUB_OVERFLOW_EN
    .c_msb (w_c_msb)
`else
    .c_msb (w_unused_c_msb)
`endif
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; DONE never accepts a new request in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_next = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = DONE;
        end else begin
          w_next = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_next = IDLE;
        end else begin
          w_next = DONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Handshake flags follow the next state so they are glitch-free flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (w_next == DONE);
      r_busy      <= (w_next == RUN) || (w_next == DONE);
    end
  end

  // Operand capture and slice-by-slice accumulation; b is pre-inverted for subtract.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_cnt       <= '0;
`ifdef ADDSUB_OVERFLOW_EN
      r_overflow  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= op_sub ? ~b : b;
            r_carry <= op_sub;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_sum[r_cnt*SLICE +: SLICE] <= w_s_k;
          r_carry                     <= w_cout;
          r_cnt                       <= r_cnt + CW'(1);
          if (w_last) begin
            r_carry_out <= w_cout;
`ifdef ADDSUB_OVERFLOW_EN
            r_overflow  <= w_c_msb ^ w_cout;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
`ifdef ADDSUB_OVERFLOW_EN
  assign overflow  = r_overflow;
`endif

endmodule

// File: tb/tb_seq_addsub_ctrl.sv
// Scoreboard bench for seq_addsub_ctrl: expected results queued at accept, checked at output.
module tb_seq_addsub_ctrl;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        carry_out;
  logic        busy;
`ifdef ADDSUB_OVERFLOW_EN
  logic        overflow;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  seq_addsub_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
`ifdef ADDSUB_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole-word reference model, no slicing.
  function automatic exp_t model(input logic sub, input logic [63:0] x, input logic [63:0] y);
    exp_t        e;
    logic [64:0] full;
    logic [63:0] yy;
    yy     = sub ? ~y : y;
    full   = sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    e.sum  = full[63:0];
    e.cout = sub ? (x >= y) : full[64];
    e.ovf  = (x[63] == yy[63]) && (e.sum[63] != x[63]);
    return e;
  endfunction

  task automatic do_op(input logic sub, input logic [63:0] x, input logic [63:0] y,
                       input int hold, input string tag);
    exp_t e;
    int   cyc;
    logic [63:0] held;
    out_ready = 1'b0;
    op_sub    = sub;
    a         = x;
    b         = y;
    in_valid  = 1'b1;
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    sb_q.push_back(model(sub, x, y));
    tick();
    in_valid = 1'b0;
    a        = ~x;
    b        = ~y;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd4);
    held = sum;
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      a        = 64'(i) * 64'h1234_5678_9ABC_DEF1;
      b        = ~a;
      tick();
      chk({tag, "_hold_sum"}, sum, held);
      chk({tag, "_hold_in_ready"}, {63'd0, in_ready}, 64'd0);
      chk({tag, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_sum"}, sum, e.sum);
      chk({tag, "_cout"}, {63'd0, carry_out}, {63'd0, e.cout});
`ifdef ADDSUB_OVERFLOW_EN
      chk({tag, "_ovf"}, {63'd0, overflow}, {63'd0, e.ovf});
`endif
    end
    tick();
    chk({tag, "_release_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_release_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_sum", sum, 64'd0);
    chk("rst_cout", {63'd0, carry_out}, 64'd0);

    do_op(1'b1, 64'd76575785, 64'd5298, 0, "t1");
    do_op(1'b1, 64'd2319840, 64'd340, 0, "t2");
    do_op(1'b1, 64'd5, 64'd7, 0, "t3");
    do_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, "t4");
    do_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, "t4_ovf");
    do_op(1'b1, 64'h8000_0000_0000_0000, 64'd1, 0, "sub_ovf");
    do_op(1'b0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 10, "t5");

    // out_ready stays high after the release: no second out_valid pulse.
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_dup_valid", {63'd0, out_valid}, 64'd0);
    end
    out_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_op(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            int'($urandom_range(0, 3)), "rand");
    end

    // Abort in the second RUN cycle.
    op_sub   = 1'b0;
    a        = 64'h1111_2222_3333_4444;
    b        = 64'h5555_6666_7777_8888;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_in_ready", {63'd0, in_ready}, 64'd1);
    chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_sum", sum, 64'd0);
    chk("t6_cout", {63'd0, carry_out}, 64'd0);
    do_op(1'b0, 64'd3, 64'd4, 0, "t6_after");

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
